// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-draining 8N1 UART transmitter.
// Holds the FSM state encoding and the framing constant.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_e;

  // One start bit, eight data bits and one stop bit.
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Baud counter: counts 0..clks_per_bit-1 while enabled and pulses tick_o on
// the terminal count. A synchronous clear holds it at zero.
module baud_tick_gen #(
  parameter int clks_per_bit = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(clks_per_bit - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a registered-read FIFO and serializes each one as an
// 8N1 UART frame, LSB first, draining back-to-back while enabled.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int data_width   = 8,
  parameter int clks_per_bit = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  empty,
  input  logic [data_width-1:0] rd_data,
  output logic                  re,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  // Index of the final data bit; the frame minus start and stop bits.
  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

  state_e                state_q, state_d;
  logic [data_width-1:0] shift_q, shift_d;
  logic [2:0]            bit_q, bit_d;
  logic                  tx_q, tx_d;
  logic                  baud_clr;
  logic                  baud_tick;

  // The counter only runs while a bit is on the line, so LOAD always clears it.
  assign baud_clr = !(state_q inside {START, DATA, STOP});

  baud_tick_gen #(
    .clks_per_bit(clks_per_bit)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clr_i (baud_clr),
    .tick_o(baud_tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (tx_en && !empty) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = rd_data;
        bit_d   = 3'd0;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        tx_d = 1'b0;
        if (baud_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
      STOP: begin
        if (baud_tick) state_d = (tx_en && !empty) ? FETCH : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // tx_d is computed from the next state so the line is a pure register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  assign re         = (state_q == FETCH);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && baud_tick;
  assign tx         = tx_q;

endmodule
